vram_arbiter: RTL and testbench

// Shares the single 8-bit VRAM between the video fetch path and CPU framebuffer writes snooped from the SE bus.

---
 rtl/vram_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single 8-bit VRAM between the video byte fetch and
// buffered CPU framebuffer writes snooped from the SE bus.
//   pixClock, reset       : pixel clock (rising edge), synchronous active-high reset
//   seq                   : pixel position in the 8-pixel byte slot (hCount[2:0])
//   vidFetch, vidAddr     : video fetch request/address, sampled only at seq==6
//   cpuWrReq/Addr/Data    : one-cycle push of a CPU write into the write FIFO
//   vramAddr/vramDataOut  : registered VRAM address / write data
//   vramDataOE            : registered data-bus drive enable
//   nvramOE, nvramWE      : registered active-low VRAM strobes
//   vidDataValid          : registered; shifter loads VRAM data this cycle
//   fifoFull              : combinational, FIFO holds DEPTH entries
//   fifoOverflow          : sticky, a push was dropped since reset
module vram_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        pixClock,
  input  logic        reset,
  input  logic [2:0]  seq,
  input  logic        vidFetch,
  input  logic [14:0] vidAddr,
  input  logic        cpuWrReq,
  input  logic [14:0] cpuWrAddr,
  input  logic [7:0]  cpuWrData,
  output logic [14:0] vramAddr,
  output logic [7:0]  vramDataOut,
  output logic        vramDataOE,
  output logic        nvramOE,
  output logic        nvramWE,
  output logic        vidDataValid,
  output logic        fifoFull,
  output logic        fifoOverflow
);

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VID  = 2'd1,
    ST_WR1  = 2'd2,
    ST_WR2  = 2'd3
  } state_e;

  state_e            state_q, state_d;

  wr_entry_t         mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [DATA_W-1:0] vram_data_q, vram_data_d;
  logic              data_oe_q, data_oe_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              vid_valid_q, vid_valid_d;

  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              wr_window;
  wr_entry_t         head;

  assign fifo_empty = (count_q == '0);
  assign fifoFull   = (count_q == CNT_W'(DEPTH));
  // Fullness is judged before any same-cycle pop, so a full FIFO rejects pushes.
  assign push       = cpuWrReq && !fifoFull;
  assign pop        = (state_d == ST_WR1);
  assign head       = mem_q[rd_ptr_q];
  // A write started at seq 5 or 6 would still be running when video owns seq 7.
  assign wr_window  = (seq == 3'd7) || (seq <= 3'd4);

  // State register
  always_ff @(posedge pixClock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision; video fetch always wins, WR1 is always followed by WR2
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WR1: state_d = ST_WR2;
      default: begin
        if (seq == 3'd6 && vidFetch) begin
          state_d = ST_VID;
        end else if (!fifo_empty && wr_window) begin
          state_d = ST_WR1;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Output values for the cycle spent in state_d; address/data hold unless reloaded
  always_comb begin
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;
    data_oe_d   = 1'b0;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    vid_valid_d = 1'b0;
    case (state_d)
      ST_VID: begin
        vram_addr_d = vidAddr;
        oe_n_d      = 1'b0;
        vid_valid_d = 1'b1;
      end
      ST_WR1: begin
        vram_addr_d = head.addr;
        vram_data_d = head.data;
        data_oe_d   = 1'b1;
        we_n_d      = 1'b0;
      end
      ST_WR2: begin
        // WE released while data stays driven: hold time for the SRAM
        data_oe_d   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Registered VRAM-side outputs
  always_ff @(posedge pixClock) begin
    if (reset) begin
      vram_addr_q <= '0;
      vram_data_q <= '0;
      data_oe_q   <= 1'b0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      vid_valid_q <= 1'b0;
    end else begin
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
      data_oe_q   <= data_oe_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      vid_valid_q <= vid_valid_d;
    end
  end

  // FIFO pointer, count and overflow next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (cpuWrReq && fifoFull) begin
      overflow_d = 1'b1;
    end
  end

  // FIFO control registers
  always_ff @(posedge pixClock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge pixClock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: cpuWrAddr, data: cpuWrData};
    end
  end

  assign vramAddr     = vram_addr_q;
  assign vramDataOut  = vram_data_q;
  assign vramDataOE   = data_oe_q;
  assign nvramOE      = oe_n_q;
  assign nvramWE      = we_n_q;
  assign vidDataValid = vid_valid_q;
  assign fifoOverflow = overflow_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: cycle table for single-write/video timing,
// hand-written sequences for overflow, sustained-full throughput and reset mid-write.
// Every observed VRAM write is checked in order against a queue of accepted pushes.
module tb_vram_arbiter;

  localparam int unsigned DEPTH = 4;

  logic        pixClock = 1'b0;
  logic        reset;
  logic [2:0]  seq;
  logic        vidFetch;
  logic [14:0] vidAddr;
  logic        cpuWrReq;
  logic [14:0] cpuWrAddr;
  logic [7:0]  cpuWrData;
  logic [14:0] vramAddr;
  logic [7:0]  vramDataOut;
  logic        vramDataOE;
  logic        nvramOE;
  logic        nvramWE;
  logic        vidDataValid;
  logic        fifoFull;
  logic        fifoOverflow;

  always #5 pixClock = ~pixClock;

  vram_arbiter #(.DEPTH(DEPTH)) dut (
    .pixClock    (pixClock),
    .reset       (reset),
    .seq         (seq),
    .vidFetch    (vidFetch),
    .vidAddr     (vidAddr),
    .cpuWrReq    (cpuWrReq),
    .cpuWrAddr   (cpuWrAddr),
    .cpuWrData   (cpuWrData),
    .vramAddr    (vramAddr),
    .vramDataOut (vramDataOut),
    .vramDataOE  (vramDataOE),
    .nvramOE     (nvramOE),
    .nvramWE     (nvramWE),
    .vidDataValid(vidDataValid),
    .fifoFull    (fifoFull),
    .fifoOverflow(fifoOverflow)
  );

  // Strobe patterns {nvramOE, nvramWE, vramDataOE, vidDataValid}
  localparam logic [3:0] S_IDLE = 4'b1100;
  localparam logic [3:0] S_VID  = 4'b0101;
  localparam logic [3:0] S_WR1  = 4'b1010;
  localparam logic [3:0] S_WR2  = 4'b1110;

  typedef struct packed {
    logic [14:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    logic        vf;
    logic [14:0] va;
    logic        wr;
    logic [14:0] wa;
    logic [7:0]  wd;
    logic [3:0]  st;
    logic [14:0] ea;
    logic [7:0]  ed;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  wr_t  sb[$];
  int   wr_at_seq [8];
  int   wr_total = 0;
  vec_t vec [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle observation: strobe rules plus in-order write scoreboard
  task automatic monitor();
    wr_t e;
    chk("strobe_rules", 32'((!nvramOE && !nvramWE) || (vramDataOE && !nvramOE)), 32'(0));
    if (nvramWE === 1'b0) begin
      wr_at_seq[seq]++;
      wr_total++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", vramAddr, vramDataOut);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(vramAddr), 32'(e.a));
        chk("wr_data", 32'(vramDataOut), 32'(e.d));
        chk("wr_data_oe", 32'(vramDataOE), 32'(1));
      end
    end
  endtask

  // One pixel clock; seq advances like hCount unless held
  task automatic tick(input bit adv);
    @(posedge pixClock);
    @(negedge pixClock);
    if (adv) seq = seq + 3'd1;
    monitor();
  endtask

  function automatic vec_t mk(input logic vf, input logic [14:0] va, input logic wr,
                              input logic [14:0] wa, input logic [7:0] wd,
                              input logic [3:0] st, input logic [14:0] ea, input logic [7:0] ed);
    vec_t v;
    v.vf = vf; v.va = va; v.wr = wr; v.wa = wa; v.wd = wd;
    v.st = st; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c;
    int   start;
    int   waited;
    bit   acc;
    bit   pop;
    vec_t v;

    // Row i is driven at seq == i%8; expectations are for the following cycle
    vec[0]  = mk(0, 15'h0000, 1, 15'h0040, 8'hA5, S_IDLE, 15'h0000, 8'h00);
    vec[1]  = mk(0, 15'h0000, 0, 15'h0000, 8'h00, S_WR1,  15'h0040, 8'hA5);
    vec[2]  = mk(0, 15'h0000, 0, 15'h0000, 8'h00, S_WR2,  15'h0040, 8'hA5);
    vec[3]  = mk(0, 15'h0000, 0, 15'h0000, 8'h00, S_IDLE, 15'h0040, 8'hA5);
    vec[4]  = mk(1, 15'h7FFF, 1, 15'h0123, 8'h3C, S_IDLE, 15'h0040, 8'hA5);
    vec[5]  = mk(1, 15'h7FFF, 0, 15'h0000, 8'h00, S_IDLE, 15'h0040, 8'hA5);
    vec[6]  = mk(1, 15'h0ABC, 0, 15'h0000, 8'h00, S_VID,  15'h0ABC, 8'hA5);
    vec[7]  = mk(1, 15'h7FFF, 0, 15'h0000, 8'h00, S_WR1,  15'h0123, 8'h3C);
    vec[8]  = mk(0, 15'h0000, 0, 15'h0000, 8'h00, S_WR2,  15'h0123, 8'h3C);
    vec[9]  = mk(0, 15'h0000, 0, 15'h0000, 8'h00, S_IDLE, 15'h0123, 8'h3C);
    for (int i = 10; i < 14; i++)
      vec[i] = mk(0, 15'h0000, 0, 15'h0000, 8'h00, S_IDLE, 15'h0123, 8'h3C);
    vec[14] = mk(1, 15'h1234, 0, 15'h0000, 8'h00, S_VID,  15'h1234, 8'h3C);
    vec[15] = mk(0, 15'h0000, 0, 15'h0000, 8'h00, S_IDLE, 15'h1234, 8'h3C);
    for (int i = 16; i < 19; i++)
      vec[i] = mk(0, 15'h0000, 0, 15'h0000, 8'h00, S_IDLE, 15'h1234, 8'h3C);
    vec[19] = mk(0, 15'h0000, 1, 15'h7001, 8'h5A, S_IDLE, 15'h1234, 8'h3C);
    vec[20] = mk(0, 15'h0000, 0, 15'h0000, 8'h00, S_WR1,  15'h7001, 8'h5A);
    vec[21] = mk(0, 15'h0000, 0, 15'h0000, 8'h00, S_WR2,  15'h7001, 8'h5A);
    vec[22] = mk(1, 15'h0F0F, 0, 15'h0000, 8'h00, S_VID,  15'h0F0F, 8'h5A);
    vec[23] = mk(0, 15'h0000, 0, 15'h0000, 8'h00, S_IDLE, 15'h0F0F, 8'h5A);

    foreach (wr_at_seq[i]) wr_at_seq[i] = 0;
    reset = 1'b1; seq = 3'd0; vidFetch = 1'b0; vidAddr = '0;
    cpuWrReq = 1'b0; cpuWrAddr = '0; cpuWrData = '0;
    tick(1);
    tick(1);

    // Reset state
    chk("rst_strobes", 32'({nvramOE, nvramWE, vramDataOE, vidDataValid}), 32'(S_IDLE));
    chk("rst_addr", 32'(vramAddr), 32'(0));
    chk("rst_data", 32'(vramDataOut), 32'(0));
    chk("rst_full", 32'(fifoFull), 32'(0));
    chk("rst_ovf", 32'(fifoOverflow), 32'(0));

    reset = 1'b0;
    while (seq != 3'd0) tick(1);

    // Single writes, video fetch, write deferred by video, write at seq 5
    for (int i = 0; i < 24; i++) begin
      v = vec[i];
      vidFetch = v.vf; vidAddr = v.va;
      cpuWrReq = v.wr; cpuWrAddr = v.wa; cpuWrData = v.wd;
      if (v.wr) sb.push_back('{a: v.wa, d: v.wd});
      tick(1);
      chk($sformatf("vec%0d_strobes", i), 32'({nvramOE, nvramWE, vramDataOE, vidDataValid}), 32'(v.st));
      chk($sformatf("vec%0d_addr", i), 32'(vramAddr), 32'(v.ea));
      chk($sformatf("vec%0d_data", i), 32'(vramDataOut), 32'(v.ed));
    end
    cpuWrReq = 1'b0; vidFetch = 1'b0;
    chk("table_drained", 32'(sb.size()), 32'(0));

    // Overflow: seq parked at 6 with vidFetch keeps video owning VRAM
    while (seq != 3'd6) tick(1);
    vidFetch = 1'b1; vidAddr = 15'h2222;
    for (int k = 0; k < 5; k++) begin
      cpuWrReq = 1'b1; cpuWrAddr = 15'h0100 + 15'(k); cpuWrData = 8'hC0 + 8'(k);
      if (k < 4) sb.push_back('{a: cpuWrAddr, d: cpuWrData});
      tick(0);
      chk($sformatf("ovf_push%0d_full", k), 32'(fifoFull), 32'(k >= 3));
      chk($sformatf("ovf_push%0d_ovf", k), 32'(fifoOverflow), 32'(k == 4));
      chk($sformatf("ovf_push%0d_vid", k), 32'({nvramOE, vidDataValid, vramAddr}), 32'({1'b0, 1'b1, 15'h2222}));
    end
    cpuWrReq = 1'b0;
    tick(0);
    chk("ovf_still_full", 32'(fifoFull), 32'(1));
    vidFetch = 1'b0;
    start = wr_total;
    repeat (20) tick(1);
    chk("ovf_writes_done", 32'(wr_total - start), 32'(4));
    chk("ovf_sb_empty", 32'(sb.size()), 32'(0));
    chk("ovf_sticky", 32'(fifoOverflow), 32'(1));
    chk("ovf_not_full", 32'(fifoFull), 32'(0));

    // Sustained full FIFO with video fetch every slot: writes only at seq 0/2/4
    while (seq != 3'd5) tick(1);
    foreach (wr_at_seq[i]) wr_at_seq[i] = 0;
    vidFetch = 1'b1; vidAddr = 15'h3333;
    c = 0;
    for (int n = 0; n < 34; n++) begin
      acc = (c < int'(DEPTH));
      pop = ((seq == 3'd7) || (seq == 3'd1) || (seq == 3'd3)) && (c > 0);
      cpuWrReq = 1'b1; cpuWrAddr = 15'h4000 + 15'(n); cpuWrData = 8'(n);
      if (acc) sb.push_back('{a: cpuWrAddr, d: cpuWrData});
      tick(1);
      c = c + int'(acc) - int'(pop);
      chk($sformatf("full_cyc%0d", n), 32'(fifoFull), 32'(c == int'(DEPTH)));
    end
    for (int s = 0; s < 8; s++)
      chk($sformatf("wr1_at_seq%0d", s), 32'(wr_at_seq[s]), 32'((s == 0 || s == 2 || s == 4) ? 4 : 0));
    cpuWrReq = 1'b0; vidFetch = 1'b0;
    repeat (16) tick(1);
    chk("full_sb_empty", 32'(sb.size()), 32'(0));

    // Reset in the middle of a write discards the queued entries
    while (seq != 3'd4) tick(1);
    for (int k = 0; k < 3; k++) begin
      cpuWrReq = 1'b1; cpuWrAddr = 15'h5550 + 15'(k); cpuWrData = 8'h90 + 8'(k);
      sb.push_back('{a: cpuWrAddr, d: cpuWrData});
      tick(1);
    end
    cpuWrReq = 1'b0;
    waited = 0;
    while (nvramWE !== 1'b0 && waited < 16) begin
      tick(1);
      waited++;
    end
    chk("rstw_wr1_seen", 32'(nvramWE), 32'(0));
    chk("rstw_ovf_before", 32'(fifoOverflow), 32'(1));
    reset = 1'b1;
    tick(1);
    sb.delete();
    chk("rstw_strobes", 32'({nvramOE, nvramWE, vramDataOE, vidDataValid}), 32'(S_IDLE));
    chk("rstw_full", 32'(fifoFull), 32'(0));
    chk("rstw_ovf", 32'(fifoOverflow), 32'(0));
    chk("rstw_addr", 32'(vramAddr), 32'(0));
    reset = 1'b0;
    start = wr_total;
    repeat (16) tick(1);
    chk("rstw_no_writes", 32'(wr_total - start), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
